// File: rtl/bfly_addsub_pipe_16b_pkg.sv
// Shared constants, types and helpers for the radix-2 butterfly add/sub stage.
//   FFT_DW / FFT_DW_EXT : native and guard-bit-extended datapath widths
//   MIN16 / MAX16       : 16-bit two's-complement limits
//   sgninv16()          : 16-bit two's-complement negation (wraps for MIN16)
//   sext17()            : sign-extend a 16-bit word to 17 bits
package bfly_addsub_pipe_16b_pkg;

  localparam int unsigned FFT_DW     = 16;
  localparam int unsigned FFT_DW_EXT = 17;

  localparam logic [FFT_DW-1:0] MIN16 = 16'h8000;
  localparam logic [FFT_DW-1:0] MAX16 = 16'h7FFF;

  // +32768 in 17 bits: the true value of -MIN16, which 16-bit negation cannot hold.
  localparam logic [FFT_DW_EXT-1:0] NEG_MIN16_EXT = 17'h0_8000;

  typedef logic [FFT_DW-1:0]     word_t;
  typedef logic [FFT_DW_EXT-1:0] ext_t;

  typedef struct packed {
    word_t re;
    word_t im;
  } cplx_t;

  function automatic word_t sgninv16(input word_t v);
    return ~v + 16'd1;
  endfunction

  function automatic ext_t sext17(input word_t v);
    return {v[FFT_DW-1], v};
  endfunction

endpackage

// File: rtl/bfly_addsub_pipe_16b_if.sv
// Stream interface of the butterfly stage: input operand pair handshake, result
// handshake and the sticky overflow flag with its clear.
//   slave  : the butterfly stage (consumes A/B, produces X/Y)
//   master : the environment driving operands and accepting results
interface bfly_addsub_pipe_16b_if;
  import bfly_addsub_pipe_16b_pkg::*;

  logic  i_valid;
  logic  o_ready;
  word_t i_a_re;
  word_t i_a_im;
  word_t i_b_re;
  word_t i_b_im;

  logic  o_valid;
  logic  i_ready;
  word_t o_x_re;
  word_t o_x_im;
  word_t o_y_re;
  word_t o_y_im;

  logic  o_ovf;
  logic  i_ovf_clr;

  modport slave (
    input  i_valid, i_a_re, i_a_im, i_b_re, i_b_im, i_ready, i_ovf_clr,
    output o_ready, o_valid, o_x_re, o_x_im, o_y_re, o_y_im, o_ovf
  );

  modport master (
    output i_valid, i_a_re, i_a_im, i_b_re, i_b_im, i_ready, i_ovf_clr,
    input  o_ready, o_valid, o_x_re, o_x_im, o_y_re, o_y_im, o_ovf
  );

endinterface

// File: rtl/bfly_addsub_pipe_16b_sat.sv
// Combinational 17-to-16 bit reduction of one butterfly result.
//   SCALE=1 : q_o = r_i >>> 1 (arithmetic, floor); ovf_o is always 0
//   SCALE=0 : q_o = r_i saturated to the 16-bit range; ovf_o flags saturation
// Ports: r_i (17-bit sum), q_o (16-bit result), ovf_o (saturation occurred)
module bfly_addsub_pipe_16b_sat
  import bfly_addsub_pipe_16b_pkg::*;
#(
  parameter bit SCALE = 1'b1
) (
  input  ext_t  r_i,
  output word_t q_o,
  output logic  ovf_o
);

  always_comb begin
    q_o   = r_i[FFT_DW-1:0];
    ovf_o = 1'b0;
    if (SCALE) begin
      q_o = r_i[FFT_DW_EXT-1:1];
    end else if (r_i[FFT_DW_EXT-1] != r_i[FFT_DW-1]) begin
      // Sign bit and 16-bit MSB disagree: the value left the 16-bit range.
      ovf_o = 1'b1;
      q_o   = r_i[FFT_DW_EXT-1] ? MIN16 : MAX16;
    end
  end

endmodule

// File: rtl/bfly_addsub_pipe_16b.sv
// Radix-2 butterfly add/sub stage: X = A + B, Y = A - B on complex 16-bit operands.
// Two-stage pipeline (operand register, result register) with valid/ready flow
// control, per-output scaling (SCALE=1) or saturation (SCALE=0), sticky overflow.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : operand/result handshakes, data, o_ovf and i_ovf_clr (slave side)
module bfly_addsub_pipe_16b
  import bfly_addsub_pipe_16b_pkg::*;
#(
  parameter bit SCALE = 1'b1
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  bfly_addsub_pipe_16b_if.slave bus
);

  // Flow control: a stage advances when its successor can take its content.
  logic en1, en2, load1, load2;

  // Stage 1 registers
  logic  s1_valid_q, s1_valid_d;
  cplx_t s1_a_q, s1_b_q, s1_nb_q;
  logic  s1_bmin_re_q, s1_bmin_im_q;

  // Stage 2 registers
  logic  o_valid_q, o_valid_d;
  cplx_t x_q, y_q;
  logic  ovf_q, ovf_d;

  // Negated B and the MIN16 markers, computed on the input side.
  word_t nb_re, nb_im;
  logic  bmin_re, bmin_im;

  // Stage 2 arithmetic
  ext_t  sum_x_re, sum_x_im, dif_y_re, dif_y_im;
  word_t sat_x_re, sat_x_im, sat_y_re, sat_y_im;
  logic  [3:0] sat_ovf;

  always_comb begin
    en2   = ~o_valid_q | bus.i_ready;
    en1   = ~s1_valid_q | en2;
    load1 = en1 & bus.i_valid;
    load2 = en2 & s1_valid_q;
  end

  assign bus.o_ready = en1;

  always_comb begin
    nb_re   = sgninv16(bus.i_b_re);
    nb_im   = sgninv16(bus.i_b_im);
    bmin_re = (bus.i_b_re == MIN16);
    bmin_im = (bus.i_b_im == MIN16);
  end

  // Bubbles clear the valid but leave the data registers untouched.
  always_comb begin
    s1_valid_d = en1 ? bus.i_valid : s1_valid_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_nb_q      <= '0;
      s1_bmin_re_q <= 1'b0;
      s1_bmin_im_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (load1) begin
        s1_a_q       <= '{re: bus.i_a_re, im: bus.i_a_im};
        s1_b_q       <= '{re: bus.i_b_re, im: bus.i_b_im};
        s1_nb_q      <= '{re: nb_re, im: nb_im};
        s1_bmin_re_q <= bmin_re;
        s1_bmin_im_q <= bmin_im;
      end
    end
  end

  // 17-bit sums; -MIN16 wraps in 16 bits, so its true value is substituted.
  always_comb begin
    sum_x_re = sext17(s1_a_q.re) + sext17(s1_b_q.re);
    sum_x_im = sext17(s1_a_q.im) + sext17(s1_b_q.im);
    dif_y_re = sext17(s1_a_q.re) + (s1_bmin_re_q ? NEG_MIN16_EXT : sext17(s1_nb_q.re));
    dif_y_im = sext17(s1_a_q.im) + (s1_bmin_im_q ? NEG_MIN16_EXT : sext17(s1_nb_q.im));
  end

  bfly_addsub_pipe_16b_sat #(.SCALE(SCALE)) u_sat_x_re (
    .r_i   (sum_x_re),
    .q_o   (sat_x_re),
    .ovf_o (sat_ovf[0])
  );

  bfly_addsub_pipe_16b_sat #(.SCALE(SCALE)) u_sat_x_im (
    .r_i   (sum_x_im),
    .q_o   (sat_x_im),
    .ovf_o (sat_ovf[1])
  );

  bfly_addsub_pipe_16b_sat #(.SCALE(SCALE)) u_sat_y_re (
    .r_i   (dif_y_re),
    .q_o   (sat_y_re),
    .ovf_o (sat_ovf[2])
  );

  bfly_addsub_pipe_16b_sat #(.SCALE(SCALE)) u_sat_y_im (
    .r_i   (dif_y_im),
    .q_o   (sat_y_im),
    .ovf_o (sat_ovf[3])
  );

  always_comb begin
    o_valid_d = en2 ? s1_valid_q : o_valid_q;
    ovf_d     = ovf_q;
    // Set has priority over a simultaneous clear.
    if (load2 && (|sat_ovf)) begin
      ovf_d = 1'b1;
    end else if (bus.i_ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      ovf_q     <= ovf_d;
      if (load2) begin
        x_q <= '{re: sat_x_re, im: sat_x_im};
        y_q <= '{re: sat_y_re, im: sat_y_im};
      end
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_x_re  = x_q.re;
  assign bus.o_x_im  = x_q.im;
  assign bus.o_y_re  = y_q.re;
  assign bus.o_y_im  = y_q.im;
  assign bus.o_ovf   = ovf_q;

endmodule

// File: tb/tb_bfly_addsub_pipe_16b.sv
// Directed bench for bfly_addsub_pipe_16b: one saturating (SCALE=0) and one
// scaling (SCALE=1) instance share clock, reset and stimulus.
module tb_bfly_addsub_pipe_16b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, rdy, clr;
  logic [15:0] a_re, a_im, b_re, b_im;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bfly_addsub_pipe_16b_if if0 ();
  bfly_addsub_pipe_16b_if if1 ();

  assign if0.i_valid   = valid;
  assign if0.i_ready   = rdy;
  assign if0.i_ovf_clr = clr;
  assign if0.i_a_re    = a_re;
  assign if0.i_a_im    = a_im;
  assign if0.i_b_re    = b_re;
  assign if0.i_b_im    = b_im;
  assign if1.i_valid   = valid;
  assign if1.i_ready   = rdy;
  assign if1.i_ovf_clr = clr;
  assign if1.i_a_re    = a_re;
  assign if1.i_a_im    = a_im;
  assign if1.i_b_re    = b_re;
  assign if1.i_b_im    = b_im;

  bfly_addsub_pipe_16b #(.SCALE(1'b0)) u_dut_sat (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if0)
  );

  bfly_addsub_pipe_16b #(.SCALE(1'b1)) u_dut_scl (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if1)
  );

  // Present one pair for one cycle; called just after a rising edge with o_ready=1.
  task automatic send(input logic [15:0] ar, ai, br, bi);
    a_re  = ar;
    a_im  = ai;
    b_re  = br;
    b_im  = bi;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Wait (bounded) for o_valid on the saturating instance; lat = falling edges waited.
  task automatic wait_out(output int lat);
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (if0.o_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    rdy   = 1'b1;
    clr   = 1'b0;
    a_re  = '0;
    a_im  = '0;
    b_re  = '0;
    b_im  = '0;
    #22;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (if0.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", if0.o_valid); end
    checks++; if (if0.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", if0.o_ready); end
    checks++; if (if0.o_x_re !== 16'h0000) begin errors++; $display("FAIL reset_x_re: got %h, expected 0000", if0.o_x_re); end
    checks++; if (if0.o_y_im !== 16'h0000) begin errors++; $display("FAIL reset_y_im: got %h, expected 0000", if0.o_y_im); end
    checks++; if (if0.o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, expected 0", if0.o_ovf); end
    checks++; if (if1.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_scl: got %b, expected 0", if1.o_valid); end
  endtask

  task automatic test_basic();
    int lat;
    send(16'd100, 16'hFFCE, 16'd30, 16'd20);
    wait_out(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d, expected 2", lat); end
    checks++; if (if0.o_x_re !== 16'h0082) begin errors++; $display("FAIL basic_x_re: got %h, expected 0082", if0.o_x_re); end
    checks++; if (if0.o_x_im !== 16'hFFE2) begin errors++; $display("FAIL basic_x_im: got %h, expected ffe2", if0.o_x_im); end
    checks++; if (if0.o_y_re !== 16'h0046) begin errors++; $display("FAIL basic_y_re: got %h, expected 0046", if0.o_y_re); end
    checks++; if (if0.o_y_im !== 16'hFFBA) begin errors++; $display("FAIL basic_y_im: got %h, expected ffba", if0.o_y_im); end
    checks++; if (if0.o_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b, expected 0", if0.o_ovf); end
    checks++; if (if1.o_x_re !== 16'h0041) begin errors++; $display("FAIL basic_scl_x_re: got %h, expected 0041", if1.o_x_re); end
    checks++; if (if1.o_x_im !== 16'hFFF1) begin errors++; $display("FAIL basic_scl_x_im: got %h, expected fff1", if1.o_x_im); end
    checks++; if (if1.o_y_re !== 16'h0023) begin errors++; $display("FAIL basic_scl_y_re: got %h, expected 0023", if1.o_y_re); end
    checks++; if (if1.o_y_im !== 16'hFFDD) begin errors++; $display("FAIL basic_scl_y_im: got %h, expected ffdd", if1.o_y_im); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ovf();
    int lat;
    send(16'h7FFF, 16'h0000, 16'h0001, 16'h0000);
    wait_out(lat);
    checks++; if (if0.o_x_re !== 16'h7FFF) begin errors++; $display("FAIL ovf_x_re: got %h, expected 7fff", if0.o_x_re); end
    checks++; if (if0.o_y_re !== 16'h7FFE) begin errors++; $display("FAIL ovf_y_re: got %h, expected 7ffe", if0.o_y_re); end
    checks++; if (if0.o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, expected 1", if0.o_ovf); end
    checks++; if (if1.o_x_re !== 16'h4000) begin errors++; $display("FAIL ovf_scl_x_re: got %h, expected 4000", if1.o_x_re); end
    checks++; if (if1.o_y_re !== 16'h3FFF) begin errors++; $display("FAIL ovf_scl_y_re: got %h, expected 3fff", if1.o_y_re); end
    checks++; if (if1.o_ovf !== 1'b0) begin errors++; $display("FAIL ovf_scl_flag: got %b, expected 0", if1.o_ovf); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (if0.o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", if0.o_ovf); end
    @(posedge clk);
    #1;
    pulse_clr();
    @(negedge clk);
    checks++; if (if0.o_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, expected 0", if0.o_ovf); end
    @(posedge clk);
    #1;
    // Clear lands on the same edge as the overflowing result load.
    send(16'h7FFF, 16'h0000, 16'h0001, 16'h0000);
    pulse_clr();
    @(negedge clk);
    checks++; if (if0.o_valid !== 1'b1) begin errors++; $display("FAIL ovf_race_valid: got %b, expected 1", if0.o_valid); end
    checks++; if (if0.o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b, expected 1", if0.o_ovf); end
    @(posedge clk);
    #1;
    pulse_clr();
  endtask

  task automatic test_bmin();
    int lat;
    checks++; if (if0.o_ovf !== 1'b0) begin errors++; $display("FAIL bmin_pre_ovf: got %b, expected 0", if0.o_ovf); end
    send(16'h0000, 16'h8000, 16'h8000, 16'h0001);
    wait_out(lat);
    checks++; if (if0.o_x_re !== 16'h8000) begin errors++; $display("FAIL bmin_x_re: got %h, expected 8000", if0.o_x_re); end
    checks++; if (if0.o_y_re !== 16'h7FFF) begin errors++; $display("FAIL bmin_y_re: got %h, expected 7fff", if0.o_y_re); end
    checks++; if (if0.o_x_im !== 16'h8001) begin errors++; $display("FAIL negsat_x_im: got %h, expected 8001", if0.o_x_im); end
    checks++; if (if0.o_y_im !== 16'h8000) begin errors++; $display("FAIL negsat_y_im: got %h, expected 8000", if0.o_y_im); end
    checks++; if (if0.o_ovf !== 1'b1) begin errors++; $display("FAIL bmin_ovf: got %b, expected 1", if0.o_ovf); end
    checks++; if (if1.o_y_re !== 16'h4000) begin errors++; $display("FAIL bmin_scl_y_re: got %h, expected 4000", if1.o_y_re); end
    checks++; if (if1.o_x_re !== 16'hC000) begin errors++; $display("FAIL bmin_scl_x_re: got %h, expected c000", if1.o_x_re); end
    checks++; if (if1.o_x_im !== 16'hC000) begin errors++; $display("FAIL negsat_scl_x_im: got %h, expected c000", if1.o_x_im); end
    checks++; if (if1.o_y_im !== 16'hBFFF) begin errors++; $display("FAIL negsat_scl_y_im: got %h, expected bfff", if1.o_y_im); end
    @(posedge clk);
    #1;
    pulse_clr();
  endtask

  task automatic test_floor();
    int lat;
    send(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    wait_out(lat);
    checks++; if (if1.o_x_re !== 16'hFFFF) begin errors++; $display("FAIL floor_scl_x_re: got %h, expected ffff", if1.o_x_re); end
    checks++; if (if1.o_y_re !== 16'hFFFF) begin errors++; $display("FAIL floor_scl_y_re: got %h, expected ffff", if1.o_y_re); end
    checks++; if (if0.o_x_re !== 16'hFFFF) begin errors++; $display("FAIL floor_x_re: got %h, expected ffff", if0.o_x_re); end
    checks++; if (if0.o_ovf !== 1'b0) begin errors++; $display("FAIL floor_ovf: got %b, expected 0", if0.o_ovf); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ar[8], ai[8], br[8], bi[8];
    logic [15:0] ex_xre[8], ex_xim[8], ex_yre[8], ex_yim[8];
    int   got = 0;
    bit   stall_seen = 1'b0;
    logic acc;
    for (int k = 0; k < 8; k++) begin
      ar[k]     = 16'(1000 * (k + 1));
      ai[k]     = 16'(-7 * (k + 1));
      br[k]     = 16'(3 * k);
      bi[k]     = 16'(50 - k);
      ex_xre[k] = ar[k] + br[k];
      ex_xim[k] = ai[k] + bi[k];
      ex_yre[k] = ar[k] - br[k];
      ex_yim[k] = ai[k] - bi[k];
    end
    rdy = 1'b1;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          a_re  = ar[k];
          a_im  = ai[k];
          b_re  = br[k];
          b_im  = bi[k];
          valid = 1'b1;
          for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            acc = if0.o_ready;
            @(posedge clk);
            #1;
            if (acc) break;
          end
        end
        valid = 1'b0;
      end
      begin
        for (int c = 0; c < 60 && got < 8; c++) begin
          @(negedge clk);
          if (!if0.o_ready) stall_seen = 1'b1;
          checks++; if ((!if0.o_valid || rdy) && !if0.o_ready) begin errors++; $display("FAIL b2b_ready_cycle%0d: got 0, expected 1", c); end
          if (if0.o_valid && rdy) begin
            checks++; if (if0.o_x_re !== ex_xre[got]) begin errors++; $display("FAIL b2b_x_re[%0d]: got %h, expected %h", got, if0.o_x_re, ex_xre[got]); end
            checks++; if (if0.o_x_im !== ex_xim[got]) begin errors++; $display("FAIL b2b_x_im[%0d]: got %h, expected %h", got, if0.o_x_im, ex_xim[got]); end
            checks++; if (if0.o_y_re !== ex_yre[got]) begin errors++; $display("FAIL b2b_y_re[%0d]: got %h, expected %h", got, if0.o_y_re, ex_yre[got]); end
            checks++; if (if0.o_y_im !== ex_yim[got]) begin errors++; $display("FAIL b2b_y_im[%0d]: got %h, expected %h", got, if0.o_y_im, ex_yim[got]); end
            got++;
          end
          @(posedge clk);
          #1;
          rdy = !((c + 1) >= 3 && (c + 1) <= 5);
        end
      end
    join
    checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d, expected 8", got); end
    checks++; if (stall_seen !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %b, expected 1", stall_seen); end
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (if0.o_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_extra%0d: got %b, expected 0", i, if0.o_valid); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    rdy = 1'b0;
    send(16'd1, 16'd2, 16'd3, 16'd4);
    send(16'd5, 16'd6, 16'd7, 16'd8);
    @(negedge clk);
    checks++; if (if0.o_valid !== 1'b1) begin errors++; $display("FAIL rstmid_full_valid: got %b, expected 1", if0.o_valid); end
    checks++; if (if0.o_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full_ready: got %b, expected 0", if0.o_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if0.o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, expected 0", if0.o_valid); end
    checks++; if (if0.o_x_re !== 16'h0000) begin errors++; $display("FAIL rstmid_x_re: got %h, expected 0000", if0.o_x_re); end
    checks++; if (if0.o_y_re !== 16'h0000) begin errors++; $display("FAIL rstmid_y_re: got %h, expected 0000", if0.o_y_re); end
    @(negedge clk);
    rst_n = 1'b1;
    rdy   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (if0.o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_pulse%0d: got %b, expected 0", i, if0.o_valid); end
    end
    @(posedge clk);
    #1;
    send(16'd10, 16'd20, 16'd1, 16'd2);
    wait_out(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rstmid_latency: got %0d, expected 2", lat); end
    checks++; if (if0.o_x_re !== 16'h000B) begin errors++; $display("FAIL rstmid_x_re_new: got %h, expected 000b", if0.o_x_re); end
    checks++; if (if0.o_y_im !== 16'h0012) begin errors++; $display("FAIL rstmid_y_im_new: got %h, expected 0012", if0.o_y_im); end
    @(posedge clk);
    #1;
    checks++; if (if1.o_ovf !== 1'b0) begin errors++; $display("FAIL scl_ovf_never: got %b, expected 0", if1.o_ovf); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf();
    test_bmin();
    test_floor();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
